// File: rtl/bin_decoder_ctrl_if.sv
// Handshake/bus bundle for bin_decoder_ctrl: control inputs and registered decode outputs.
interface bin_decoder_ctrl_if #(
    parameter int IN_W = 3
);
    localparam int OUT_W = 2 ** IN_W;

    logic              en;
    logic [1:0]        mode;
    logic [IN_W-1:0]   code_in;
    logic              code_vld;
    logic [OUT_W-1:0]  out;
    logic              busy;
    logic              done;

    modport master (
        output en, mode, code_in, code_vld,
        input  out, busy, done
    );

    modport slave (
        input  en, mode, code_in, code_vld,
        output out, busy, done
    );
endinterface

// File: rtl/bin_decoder_ctrl.sv
// Binary-to-one-hot decoder with level, fixed-length pulse and free-running scan modes.
module bin_decoder_ctrl #(
    parameter int IN_W      = 3,
    parameter int PULSE_LEN = 4,
    parameter int SCAN_DIV  = 8
) (
    input  logic              Clk,
    input  logic              Rst,
    bin_decoder_ctrl_if.slave bus
);
    localparam int OUT_W = 2 ** IN_W;
    localparam int SW    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int PW    = (PULSE_LEN > 1) ? $clog2(PULSE_LEN) : 1;

    localparam logic [SW-1:0]   STEP_LAST  = SW'(SCAN_DIV - 1);
    localparam logic [PW-1:0]   PULSE_LAST = PW'(PULSE_LEN - 1);
    localparam logic [IN_W-1:0] IDX_LAST   = IN_W'(OUT_W - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_HOLD  = 2'd1;
    localparam logic [1:0] S_PULSE = 2'd2;
    localparam logic [1:0] S_SCAN  = 2'd3;

    localparam logic [1:0] M_LEVEL = 2'b00;
    localparam logic [1:0] M_PULSE = 2'b01;
    localparam logic [1:0] M_SCAN  = 2'b10;
    localparam logic [1:0] M_RSVD  = 2'b11;

    logic [1:0]       state;
    logic [1:0]       mode_q;
    logic [SW-1:0]    step_cnt;
    logic [PW-1:0]    pulse_cnt;
    logic [IN_W-1:0]  idx;
    logic [IN_W-1:0]  idx_next;
    logic [OUT_W-1:0] out_r;
    logic             busy_r;
    logic             done_r;
    logic             force_idle;

    function automatic logic [OUT_W-1:0] onehot(input logic [IN_W-1:0] c);
        logic [OUT_W-1:0] v;
        v    = '0;
        v[c] = 1'b1;
        return v;
    endfunction

    // Any mode change costs one idle cycle so the new mode always starts from a clean state.
    assign force_idle = !bus.en || (bus.mode == M_RSVD) || (bus.mode != mode_q);
    assign idx_next   = idx + 1'b1;

    always_ff @(posedge Clk) begin
        // mode_q follows the input even in reset so the first post-reset cycle is not a "change".
        mode_q <= bus.mode;
        done_r <= 1'b0;
        if (Rst || force_idle) begin
            state     <= S_IDLE;
            out_r     <= '0;
            busy_r    <= 1'b0;
            step_cnt  <= '0;
            pulse_cnt <= '0;
            idx       <= '0;
        end else begin
            case (bus.mode)
                M_LEVEL: begin
                    if (bus.code_vld) begin
                        out_r <= onehot(bus.code_in);
                        state <= S_HOLD;
                    end
                end
                M_PULSE: begin
                    if (state == S_PULSE) begin
                        if (pulse_cnt == PULSE_LAST) begin
                            state     <= S_IDLE;
                            out_r     <= '0;
                            busy_r    <= 1'b0;
                            done_r    <= 1'b1;
                            pulse_cnt <= '0;
                        end else begin
                            pulse_cnt <= pulse_cnt + 1'b1;
                        end
                    end else if (bus.code_vld) begin
                        state     <= S_PULSE;
                        out_r     <= onehot(bus.code_in);
                        busy_r    <= 1'b1;
                        pulse_cnt <= '0;
                    end
                end
                M_SCAN: begin
                    if (state == S_SCAN) begin
                        if (step_cnt == STEP_LAST) begin
                            step_cnt <= '0;
                            idx      <= idx_next;
                            out_r    <= onehot(idx_next);
                            done_r   <= (idx == IDX_LAST);
                        end else begin
                            step_cnt <= step_cnt + 1'b1;
                        end
                    end else begin
                        state    <= S_SCAN;
                        idx      <= '0;
                        out_r    <= onehot('0);
                        busy_r   <= 1'b1;
                        step_cnt <= '0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.out  = out_r;
    assign bus.busy = busy_r;
    assign bus.done = done_r;
endmodule

// File: tb/tb_bin_decoder_ctrl.sv
// Directed bench for bin_decoder_ctrl: level, pulse, scan, abort paths and an IN_W sweep.
module tb_bin_decoder_ctrl;
    logic Clk = 1'b0;
    logic Rst;
    int   checks = 0;
    int   errors = 0;

    always #5 Clk = ~Clk;

    bin_decoder_ctrl_if #(.IN_W(3)) bus3 ();
    bin_decoder_ctrl_if #(.IN_W(1)) bus1 ();
    bin_decoder_ctrl_if #(.IN_W(6)) bus6 ();

    bin_decoder_ctrl #(.IN_W(3), .PULSE_LEN(4), .SCAN_DIV(2)) dut3 (
        .Clk(Clk), .Rst(Rst), .bus(bus3.slave)
    );
    bin_decoder_ctrl #(.IN_W(1), .PULSE_LEN(4), .SCAN_DIV(2)) dut1 (
        .Clk(Clk), .Rst(Rst), .bus(bus1.slave)
    );
    bin_decoder_ctrl #(.IN_W(6), .PULSE_LEN(4), .SCAN_DIV(2)) dut6 (
        .Clk(Clk), .Rst(Rst), .bus(bus6.slave)
    );

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk3(input string tag, input logic [7:0] o, input logic b, input logic d);
        chk({tag, ".out"},  64'(bus3.out),  64'(o));
        chk({tag, ".busy"}, 64'(bus3.busy), 64'(b));
        chk({tag, ".done"}, 64'(bus3.done), 64'(d));
    endtask

    task automatic drv(input logic e, input logic [1:0] m, input logic [2:0] c, input logic v);
        bus3.en       = e;
        bus3.mode     = m;
        bus3.code_in  = c;
        bus3.code_vld = v;
    endtask

    initial begin
        logic [7:0]  e8;
        logic [1:0]  exp1;
        logic [63:0] exp6;
        logic        v1;
        logic        v6;

        Rst = 1'b1;
        drv(1'b0, 2'b00, 3'd0, 1'b0);
        bus1.en = 1'b1; bus1.mode = 2'b00; bus1.code_in = '0; bus1.code_vld = 1'b0;
        bus6.en = 1'b1; bus6.mode = 2'b00; bus6.code_in = '0; bus6.code_vld = 1'b0;
        tick();
        tick();
        chk3("reset", 8'h00, 1'b0, 1'b0);

        // Level: strobe accepted on the very first cycle out of reset, then codes 1..7.
        Rst = 1'b0;
        drv(1'b1, 2'b00, 3'd0, 1'b1);
        tick();
        chk3("level0", 8'h01, 1'b0, 1'b0);
        for (int k = 1; k < 8; k++) begin
            bus3.code_in = 3'(k);
            tick();
            e8 = 8'd1 << k;
            chk3("level_seq", e8, 1'b0, 1'b0);
        end
        bus3.code_vld = 1'b0;
        tick();
        chk3("level_hold", 8'h80, 1'b0, 1'b0);

        // Pulse: mode change idles one cycle, then code 5 for four cycles.
        drv(1'b1, 2'b01, 3'd0, 1'b0);
        tick();
        chk3("pulse_modechg", 8'h00, 1'b0, 1'b0);
        drv(1'b1, 2'b01, 3'd5, 1'b1);
        tick();
        chk3("pulse_c1", 8'h20, 1'b1, 1'b0);
        bus3.code_vld = 1'b0;
        tick();
        chk3("pulse_c2", 8'h20, 1'b1, 1'b0);
        drv(1'b1, 2'b01, 3'd2, 1'b1);
        tick();
        chk3("pulse_c3_ignore", 8'h20, 1'b1, 1'b0);
        bus3.code_vld = 1'b0;
        tick();
        chk3("pulse_c4", 8'h20, 1'b1, 1'b0);
        tick();
        chk3("pulse_done", 8'h00, 1'b0, 1'b1);
        drv(1'b1, 2'b01, 3'd3, 1'b1);
        tick();
        chk3("b2b_c1", 8'h08, 1'b1, 1'b0);
        bus3.code_vld = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk3("b2b_run", 8'h08, 1'b1, 1'b0);
        end
        tick();
        chk3("b2b_done", 8'h00, 1'b0, 1'b1);
        tick();
        chk3("b2b_after", 8'h00, 1'b0, 1'b0);

        // Reset in the middle of a pulse: no done strobe afterwards.
        drv(1'b1, 2'b01, 3'd6, 1'b1);
        tick();
        chk3("rstp_c1", 8'h40, 1'b1, 1'b0);
        bus3.code_vld = 1'b0;
        tick();
        Rst = 1'b1;
        tick();
        chk3("rstp_abort", 8'h00, 1'b0, 1'b0);
        Rst = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk3("rstp_quiet", 8'h00, 1'b0, 1'b0);
        end

        // Scan with SCAN_DIV=2; strobes during scan must be ignored.
        drv(1'b1, 2'b10, 3'd0, 1'b0);
        tick();
        chk3("scan_modechg", 8'h00, 1'b0, 1'b0);
        drv(1'b1, 2'b10, 3'd5, 1'b1);
        for (int t = 0; t < 20; t++) begin
            tick();
            e8 = 8'd1 << ((t / 2) % 8);
            chk3("scan_step", e8, 1'b1, (t == 16));
        end

        // Switch to level mid-scan with a simultaneous strobe: code dropped.
        drv(1'b1, 2'b00, 3'd4, 1'b1);
        tick();
        chk3("abort_scan", 8'h00, 1'b0, 1'b0);
        bus3.code_vld = 1'b0;
        tick();
        chk3("dropped_code", 8'h00, 1'b0, 1'b0);
        drv(1'b1, 2'b00, 3'd4, 1'b1);
        tick();
        chk3("level_after", 8'h10, 1'b0, 1'b0);
        drv(1'b0, 2'b00, 3'd1, 1'b1);
        tick();
        chk3("en_low", 8'h00, 1'b0, 1'b0);
        drv(1'b1, 2'b00, 3'd1, 1'b0);
        tick();
        chk3("en_back", 8'h00, 1'b0, 1'b0);
        drv(1'b1, 2'b11, 3'd2, 1'b1);
        tick();
        chk3("mode_rsvd", 8'h00, 1'b0, 1'b0);
        tick();
        chk3("mode_rsvd2", 8'h00, 1'b0, 1'b0);

        // Reset mid-scan, then scan restarts from index 0 without done.
        drv(1'b1, 2'b10, 3'd0, 1'b0);
        tick();
        chk3("scan2_chg", 8'h00, 1'b0, 1'b0);
        tick();
        chk3("scan2_entry", 8'h01, 1'b1, 1'b0);
        tick();
        tick();
        chk3("scan2_step", 8'h02, 1'b1, 1'b0);
        Rst = 1'b1;
        tick();
        chk3("scan2_rst", 8'h00, 1'b0, 1'b0);
        Rst = 1'b0;
        tick();
        chk3("scan2_reentry", 8'h01, 1'b1, 1'b0);

        // Parameter sweep against a reference decode model.
        exp1 = '0;
        exp6 = '0;
        for (int n = 0; n < 60; n++) begin
            v1 = 1'($urandom_range(0, 1));
            v6 = 1'($urandom_range(0, 1));
            bus1.code_vld = v1;
            bus1.code_in  = 1'($urandom_range(0, 1));
            bus6.code_vld = v6;
            bus6.code_in  = 6'($urandom_range(0, 63));
            if (v1) exp1 = 2'd1 << bus1.code_in;
            if (v6) exp6 = 64'd1 << bus6.code_in;
            tick();
            chk("sweep1.out", 64'(bus1.out), 64'(exp1));
            chk("sweep6.out", bus6.out, exp6);
            chk("sweep6.onehot0", 64'($onehot0(bus6.out)), 64'd1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
